// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: access function codes, FSM states
// and the store-lane / alignment helpers used by the arbiter datapath.
package mem_port_arbiter_pkg;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_SB  = 3'b011;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_e;

  function automatic logic is_store(input logic [2:0] fn);
    is_store = (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] fn, input logic [1:0] off);
    case (fn)
      MEM_LW, MEM_SW:          misaligned = (off != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: misaligned = off[0];
      default:                 misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_we(input logic [2:0] fn, input logic [1:0] off);
    case (fn)
      MEM_SW:  store_we = 4'b1111;
      MEM_SH:  store_we = off[1] ? 4'b1100 : 4'b0011;
      MEM_SB:  store_we = 4'b0001 << off;
      default: store_we = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] fn, input logic [31:0] wdata);
    case (fn)
      MEM_SB:  store_lanes = {4{wdata[7:0]}};
      MEM_SH:  store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the arbiter and its
// requesters; the slave view is the arbiter's, the master view the environment's.
interface mem_port_arbiter_if #(parameter int DATA_LEN = 32);

  logic                if_req;
  logic [DATA_LEN-1:0] if_addr;
  logic                if_ready;
  logic [DATA_LEN-1:0] if_rdata;

  logic                dm_req;
  logic [2:0]          dm_fn;
  logic [DATA_LEN-1:0] dm_addr;
  logic [DATA_LEN-1:0] dm_wdata;
  logic                dm_ready;
  logic [DATA_LEN-1:0] dm_rdata;
  logic                dm_misalign;

  logic                mem_en;
  logic [3:0]          mem_we;
  logic [DATA_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [DATA_LEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_fn, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata, dm_misalign,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_fn, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata, dm_misalign,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_load_align.sv
// Extracts and sign/zero-extends the addressed byte or halfword of a read word;
// store codes yield zero so the data response for a store reads back as 0.
module mem_load_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  i_fn,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_data = '0;
    case (i_fn)
      MEM_LW:  o_data = i_word;
      MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_data = {16'h0000, w_half};
      MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {24'h000000, w_byte};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, data-first
// with a starvation guard; one transaction in flight, completion the following cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_LEN     = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [SW-1:0] r_starve;
  logic [2:0]    r_fn;
  logic [1:0]    r_off;

  logic          w_if_mis;
  logic          w_dm_mis;
  logic          w_i_elig;
  logic          w_d_elig;
  logic          w_i_win;
  logic          w_d_win;
  logic [31:0]   w_load;

  mem_load_align u_align (
    .i_fn   (r_fn),
    .i_off  (r_off),
    .i_word (bus.mem_rdata),
    .o_data (w_load)
  );

  // A misaligned request answers in the cycle it is taken, so it must wait while
  // the same port is already receiving its response this cycle.
  always_comb begin
    w_if_mis = (bus.if_addr[1:0] != 2'b00);
    w_dm_mis = misaligned(bus.dm_fn, bus.dm_addr[1:0]);
    w_i_elig = bus.if_req & ~(w_if_mis & (r_state == I_WAIT));
    w_d_elig = bus.dm_req & ~(w_dm_mis & (r_state == D_WAIT));
    w_i_win  = reset_n & w_i_elig & (~w_d_elig | (r_starve == LIM));
    w_d_win  = reset_n & w_d_elig & ~w_i_win;
  end

  always_comb begin
    w_next          = IDLE;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 4'b0000;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.if_ready    = 1'b0;
    bus.if_rdata    = '0;
    bus.dm_ready    = 1'b0;
    bus.dm_rdata    = '0;
    bus.dm_misalign = 1'b0;

    case (r_state)
      I_WAIT: begin
        bus.if_ready = 1'b1;
        bus.if_rdata = bus.mem_rdata;
      end
      D_WAIT: begin
        bus.dm_ready = 1'b1;
        bus.dm_rdata = w_load;
      end
      default: ;
    endcase

    if (w_i_win) begin
      if (w_if_mis) begin
        bus.if_ready = 1'b1;
        bus.if_rdata = NOP_INSN;
      end else begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {bus.if_addr[DATA_LEN-1:2], 2'b00};
        w_next       = I_WAIT;
      end
    end

    if (w_d_win) begin
      if (w_dm_mis) begin
        bus.dm_ready    = 1'b1;
        bus.dm_misalign = 1'b1;
        bus.dm_rdata    = '0;
      end else begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {bus.dm_addr[DATA_LEN-1:2], 2'b00};
        if (is_store(bus.dm_fn)) begin
          bus.mem_we    = store_we(bus.dm_fn, bus.dm_addr[1:0]);
          bus.mem_wdata = store_lanes(bus.dm_fn, bus.dm_wdata);
        end
        w_next = D_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_fn     <= '0;
      r_off    <= '0;
    end else begin
      r_state <= w_next;
      if (!bus.if_req || w_i_win) begin
        r_starve <= '0;
      end else if (r_starve != LIM) begin
        r_starve <= r_starve + SW'(1);
      end
      if (w_d_win && !w_dm_mis) begin
        r_fn  <= bus.dm_fn;
        r_off <= bus.dm_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level
// reference model of grants, starvation and load/store formatting.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_LEN(32)) bus();

  mem_port_arbiter #(.DATA_LEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // memory device: sole writer of phys (preload port or DUT writes)
  logic [31:0] phys [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_we) begin
      phys[pre_idx] <= pre_val;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= phys[bus.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) phys[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] ref_mem [256];
  int          pend;       // 0 none, 1 fetch response due, 2 data response due
  logic [31:0] pend_val;
  int          starve;
  bit          g_fetch, g_data;

  logic        o_en, o_if_ready, o_dm_ready, o_mis;
  logic [3:0]  o_we;
  logic [31:0] o_addr, o_wdata, o_if_rdata, o_dm_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_en"},     32'(bus.mem_en), 32'h0);
    chk({pfx, "_we"},     32'(bus.mem_we), 32'h0);
    chk({pfx, "_addr"},   bus.mem_addr, 32'h0);
    chk({pfx, "_wdata"},  bus.mem_wdata, 32'h0);
    chk({pfx, "_ifrdy"},  32'(bus.if_ready), 32'h0);
    chk({pfx, "_ifdat"},  bus.if_rdata, 32'h0);
    chk({pfx, "_dmrdy"},  32'(bus.dm_ready), 32'h0);
    chk({pfx, "_dmdat"},  bus.dm_rdata, 32'h0);
    chk({pfx, "_mis"},    32'(bus.dm_misalign), 32'h0);
  endtask

  // One clock cycle: predict, sample at the falling edge, compare, commit model.
  task automatic cycle();
    logic [31:0] e_if_rdata, e_dm_rdata, e_addr, e_wdata, pv, w;
    logic        e_if_ready, e_dm_ready, e_mis, e_en;
    logic [3:0]  e_we;
    bit          f_mis, d_mis, f_ok, d_ok, fw, dw, st;
    int          off, size, next_pend, idx;
    logic [2:0]  fn;
    e_if_rdata = 0; e_dm_rdata = 0; e_addr = 0; e_wdata = 0; pv = 0;
    e_if_ready = 0; e_dm_ready = 0; e_mis = 0; e_en = 0; e_we = 0;
    next_pend = 0; st = 0; idx = 0;
    fn   = bus.dm_fn;
    off  = int'(bus.dm_addr % 4);
    size = (fn == MEM_LW || fn == MEM_SW) ? 4 :
           (fn == MEM_LH || fn == MEM_LHU || fn == MEM_SH) ? 2 : 1;

    if (pend == 1) begin e_if_ready = 1; e_if_rdata = pend_val; end
    if (pend == 2) begin e_dm_ready = 1; e_dm_rdata = pend_val; end

    f_mis = (bus.if_addr % 4) != 0;
    d_mis = (bus.dm_addr % size) != 0;
    f_ok  = bus.if_req && !(f_mis && pend == 1);
    d_ok  = bus.dm_req && !(d_mis && pend == 2);
    fw    = f_ok && (!d_ok || starve == LIMIT);
    dw    = d_ok && !fw;

    if (fw) begin
      if (f_mis) begin
        e_if_ready = 1; e_if_rdata = 32'h0000_0013;
      end else begin
        e_en = 1; e_addr = bus.if_addr & ~32'h3;
        pv = ref_mem[e_addr[9:2]]; next_pend = 1;
      end
    end
    if (dw) begin
      if (d_mis) begin
        e_dm_ready = 1; e_mis = 1; e_dm_rdata = 0;
      end else begin
        e_en = 1; e_addr = bus.dm_addr & ~32'h3; idx = int'(e_addr[9:2]);
        next_pend = 2;
        st = (fn == MEM_SB || fn == MEM_SH || fn == MEM_SW);
        if (st) begin
          if (size == 4)      begin e_we = 4'hF; e_wdata = bus.dm_wdata; end
          else if (size == 2) begin e_we = 4'(3 << off); e_wdata = (bus.dm_wdata & 32'hFFFF) * 32'h0001_0001; end
          else                begin e_we = 4'(1 << off); e_wdata = (bus.dm_wdata & 32'hFF) * 32'h0101_0101; end
          pv = 0;
        end else begin
          w = ref_mem[idx] >> (8 * off);
          case (fn)
            MEM_LW:  pv = w;
            MEM_LH:  pv = {{16{w[15]}}, w[15:0]};
            MEM_LHU: pv = {16'h0, w[15:0]};
            MEM_LB:  pv = {{24{w[7]}}, w[7:0]};
            default: pv = {24'h0, w[7:0]};
          endcase
        end
      end
    end

    @(negedge clk);
    o_en = bus.mem_en; o_we = bus.mem_we; o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
    o_if_ready = bus.if_ready; o_if_rdata = bus.if_rdata;
    o_dm_ready = bus.dm_ready; o_dm_rdata = bus.dm_rdata; o_mis = bus.dm_misalign;
    chk("mem_en",      32'(o_en), 32'(e_en));
    chk("mem_we",      32'(o_we), 32'(e_we));
    chk("mem_addr",    o_addr, e_addr);
    chk("mem_wdata",   o_wdata, e_wdata);
    chk("if_ready",    32'(o_if_ready), 32'(e_if_ready));
    chk("if_rdata",    o_if_rdata, e_if_rdata);
    chk("dm_ready",    32'(o_dm_ready), 32'(e_dm_ready));
    chk("dm_rdata",    o_dm_rdata, e_dm_rdata);
    chk("dm_misalign", 32'(o_mis), 32'(e_mis));

    @(posedge clk);
    if (st)
      for (int b = 0; b < 4; b++)
        if (e_we[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
    pend     = next_pend;
    pend_val = pv;
    starve   = (!bus.if_req || fw) ? 0 : ((starve + 1 > LIMIT) ? LIMIT : starve + 1);
    g_fetch  = fw;
    g_data   = dw;
    #1;
  endtask

  task automatic new_fetch();
    bus.if_req  = ($urandom_range(0, 3) != 0);
    bus.if_addr = 32'h100 + 32'(4 * $urandom_range(0, 15)) +
                  (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
  endtask

  task automatic new_data();
    int word, o;
    logic [2:0] fn;
    fn   = 3'($urandom_range(0, 7));
    word = $urandom_range(0, 15);
    if ($urandom_range(0, 5) == 0) o = $urandom_range(0, 3);
    else if (fn == MEM_LW || fn == MEM_SW) o = 0;
    else if (fn == MEM_LH || fn == MEM_LHU || fn == MEM_SH) o = 2 * $urandom_range(0, 1);
    else o = $urandom_range(0, 3);
    bus.dm_req   = ($urandom_range(0, 3) != 0);
    bus.dm_fn    = fn;
    bus.dm_addr  = 32'h100 + 32'(4 * word + o);
    bus.dm_wdata = $urandom;
  endtask

  logic [9:0] pat;

  initial begin
    reset_n = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_fn = MEM_LW; bus.dm_addr = 0; bus.dm_wdata = 0;
    pend = 0; pend_val = 0; starve = 0; g_fetch = 0; g_data = 0;

    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      pre_idx = 8'(i);
      pre_val = (i == 4) ? 32'h0050_0513 : $urandom;
      ref_mem[i] = pre_val;
      pre_we = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    // outputs must stay quiet under reset even with requests pending
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.dm_req = 1; bus.dm_fn = MEM_LW; bus.dm_addr = 32'h104;
    #2 chk_all_zero("reset");
    bus.if_req = 0; bus.dm_req = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    cycle();   // idle cycle
    chk("idle_en", 32'(o_en), 32'h0);

    // fetch from 0x10
    bus.if_req = 1; bus.if_addr = 32'h10;
    cycle();
    chk("f027_en",   32'(o_en), 32'h1);
    chk("f027_addr", o_addr, 32'h10);
    bus.if_req = 0;
    cycle();
    chk("f027_ready", 32'(o_if_ready), 32'h1);
    chk("f027_rdata", o_if_rdata, 32'h0050_0513);

    // continuous contention: four data grants then one fetch
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.dm_req = 1; bus.dm_fn = MEM_LW; bus.dm_addr = 32'h104;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      pat[i] = (o_en && o_addr == 32'h20);
    end
    chk("starve_pattern", 32'(pat), 32'h210);
    bus.if_req = 0; bus.dm_req = 0;
    cycle();

    // SB then LB / LBU of the same byte
    bus.dm_req = 1; bus.dm_fn = MEM_SB; bus.dm_addr = 32'h103; bus.dm_wdata = 32'hAB;
    cycle();
    chk("sb_we",   32'(o_we), 32'h8);
    chk("sb_lane", o_wdata >> 24, 32'hAB);
    bus.dm_fn = MEM_LB;
    cycle();
    chk("sb_rsp_zero", o_dm_rdata, 32'h0);
    bus.dm_fn = MEM_LBU;
    cycle();
    chk("lb_sext", o_dm_rdata, 32'hFFFF_FFAB);
    bus.dm_req = 0;
    cycle();
    chk("lbu_zext", o_dm_rdata, 32'h0000_00AB);

    // misaligned LW
    bus.dm_req = 1; bus.dm_fn = MEM_LW; bus.dm_addr = 32'h102;
    cycle();
    chk("mis_en",    32'(o_en), 32'h0);
    chk("mis_flag",  32'(o_mis), 32'h1);
    chk("mis_ready", 32'(o_dm_ready), 32'h1);
    bus.dm_req = 0;
    cycle();
    chk("mis_no_wait", 32'(o_dm_ready), 32'h0);

    // reset while a data response is due
    bus.dm_req = 1; bus.dm_fn = MEM_LW; bus.dm_addr = 32'h108;
    cycle();
    reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    bus.dm_req = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    pend = 0; starve = 0;
    cycle();
    chk("post_rst_no_ready", 32'(o_dm_ready), 32'h0);
    cycle();

    // randomized traffic; each requester holds its request until granted
    new_fetch();
    new_data();
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (g_fetch || !bus.if_req) new_fetch();
      if (g_data || !bus.dm_req) new_data();
    end
    bus.if_req = 0; bus.dm_req = 0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_LEN, 32, data/address width.
REQ-002 SHALL have parameter STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset_n input 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: if_req input 1, fetch request; if_addr input 32, fetch byte address; if_ready output 1, fetch response valid; if_rdata output 32, instruction word.
REQ-005 SHALL have ports: dm_req input 1, data request; dm_fn input 3, `MEM_* code; dm_addr input 32, data byte address; dm_wdata input 32, store data; dm_ready output 1, data access complete; dm_rdata output 32, formatted load data; dm_misalign output 1, misaligned-access pulse.
REQ-006 SHALL have ports: mem_en output 1, port enable; mem_we output 4, byte write enables; mem_addr output 32, word address (byte address with [1:0]=0); mem_wdata output 32, lane-aligned store data; mem_rdata input 32, read word, valid one cycle after mem_en.

Function
REQ-007 SHALL implement FSM with states IDLE, I_WAIT, D_WAIT; one outstanding transaction maximum.
REQ-008 SHALL, in IDLE or in the final cycle of a WAIT state, select a grant combinationally, drive mem_en=1 for that request in that cycle, and enter I_WAIT or D_WAIT at the next edge.
REQ-009 SHALL grant data over fetch when both request, unless starve counter == STARVE_LIMIT, in which case fetch wins.
REQ-010 SHALL increment starve counter (saturating at STARVE_LIMIT) each cycle fetch requests but is not granted; clear it on fetch grant or when if_req=0.
REQ-011 SHALL, in I_WAIT, assert if_ready=1 for exactly one cycle with if_rdata=mem_rdata.
REQ-012 SHALL, in D_WAIT, assert dm_ready=1 for exactly one cycle; for loads dm_rdata = formatted mem_rdata; for stores dm_rdata=0.
REQ-013 SHALL require requesters to hold req/addr/fn/wdata stable until their ready; behaviour on early withdrawal is undefined but SHALL NOT hang the FSM.
REQ-014 SHALL derive mem_we from dm_fn and dm_addr[1:0]: SW 4'b1111; SH 4'b0011 or 4'b1100; SB one-hot by addr[1:0]; loads and fetches 4'b0000.
REQ-015 SHALL replicate store bytes/halfwords to the addressed lane on mem_wdata.
REQ-016 SHALL format loads using fn and addr[1:0] registered at grant: LW word; LH/LHU halfword sign/zero-extended; LB/LBU byte sign/zero-extended.
REQ-017 SHALL, for misaligned data access (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]=1), not assert mem_en, pulse dm_misalign=1 and dm_ready=1 in the same cycle, remain in/return to IDLE.
REQ-018 SHALL treat misaligned fetch (if_addr[1:0]!=0) the same way: no memory access, if_ready=1 with if_rdata=32'h00000013 (NOP).
REQ-019 SHALL, with no requests, hold mem_en=0 and stay IDLE; ready outputs SHALL be 0 outside the cycles above.
REQ-020 SHALL give zero-wait back-to-back throughput: one completion per cycle after the first when requests are continuous.

Reset
REQ-021 SHALL, on reset_n=0, immediately force state IDLE, starve counter 0, registered fn/addr 0, and all outputs 0 (if_rdata, dm_rdata 32'h0; mem_we 4'b0).
REQ-022 SHALL abandon an in-flight transaction on reset mid-operation; no ready pulse is produced for it after reset release.
REQ-023 SHALL begin arbitration on the first rising edge after reset_n deasserts.

Structure
REQ-024 SHALL take `MEM_LB/LH/LW/LBU/LHU/SB/SH/SW encodings from the shared define.vh; no local redefinition.
REQ-025 SHALL place STARVE_LIMIT default and FSM state encodings in define.vh as shared constants.
REQ-026 SHALL contain one sub-module, mem_load_align, performing REQ-016 combinationally.

Verification
REQ-027 Fetch only, if_addr=0x00000010, mem holds 0x00500513 -> mem_en at cycle 0, if_ready=1 with if_rdata=0x00500513 at cycle 1.
REQ-028 Both request every cycle, STARVE_LIMIT=4 -> four data grants, then one fetch grant, pattern repeating.
REQ-029 SB addr=0x103 wdata=0x000000AB -> mem_we=4'b1000, mem_wdata[31:24]=0xAB; then LB 0x103 -> dm_rdata=0xFFFFFFAB; LBU -> 0x000000AB.
REQ-030 LW addr=0x102 -> no mem_en, dm_misalign=1 and dm_ready=1 same cycle, state stays IDLE.
REQ-031 reset_n=0 during D_WAIT -> outputs 0 asynchronously; after release no dm_ready until a new request is granted.
